// File: rtl/bvh_traverse_ctrl.sv
// bvh_traverse_ctrl: walks a BVH for one ray, issuing node fetches and ray/box tests and streaming leaf hits.
// Define BVH_TRAV_STATS_EN to add saturating node-test and leaf-hit counters.
module bvh_traverse_ctrl #(
    parameter int FRA_BITS    = 16,
    parameter int NODE_AW     = 16,
    parameter int PRIM_W      = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic signed [0:1][0:2][31:0]     i_ray,
    input  logic [NODE_AW-1:0]               i_root,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_overflow,
    output logic                             o_node_rd,
    output logic [NODE_AW-1:0]               o_node_addr,
    input  logic                             i_node_rvalid,
    input  logic signed [0:1][0:2][31:0]     i_node_bbox,
    input  logic                             i_node_leaf,
    input  logic [NODE_AW-1:0]               i_node_left,
    input  logic [NODE_AW-1:0]               i_node_right,
    input  logic [PRIM_W-1:0]                i_node_prim,
    output logic                             o_test_start,
    output logic signed [0:1][0:2][31:0]     o_test_ray,
    output logic signed [0:1][0:2][31:0]     o_test_bbox,
    input  logic                             i_test_done,
    input  logic                             i_test_hit,
    output logic                             o_leaf_valid,
    output logic [PRIM_W-1:0]                o_leaf_prim,
    input  logic                             i_leaf_ready
`ifdef BVH_TRAV_STATS_EN
    ,
    output logic [15:0]                      o_nodes_tested,
    output logic [15:0]                      o_leaves_hit
`endif
);
    localparam int SA = $clog2(STACK_DEPTH);
    localparam logic [SA:0] FULL = (SA+1)'(STACK_DEPTH);

    // Ray/bbox words are fixed-point with FRA_BITS fraction; this block only moves them.
    if (FRA_BITS > 31) begin : g_fra_unsupported
    end

    typedef enum logic [3:0] {IDLE, POP, FETCH, WAITN, TEST, WAITT, EMIT, PUSHR, PUSHL, DONE} state_t;

    state_t              state;
    logic [SA:0]         sp;
    logic [SA-1:0]       top_idx;
    logic [NODE_AW-1:0]  stack [STACK_DEPTH];
    logic                leaf;
    logic [NODE_AW-1:0]  left, right;
    logic [PRIM_W-1:0]   prim;
    logic                push;
    logic [SA-1:0]       push_idx;
    logic [NODE_AW-1:0]  push_val;

    assign top_idx = SA'(sp - 1'b1);

    always_comb begin
        push     = (state == IDLE && i_start) || ((state == PUSHR || state == PUSHL) && sp != FULL);
        push_idx = state == IDLE ? '0 : sp[SA-1:0];
        push_val = state == IDLE ? i_root : state == PUSHR ? right : left;
    end

    // Stack storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge i_clk)
        if (push) stack[push_idx] <= push_val;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            sp           <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_node_rd    <= 1'b0;
            o_node_addr  <= '0;
            o_test_start <= 1'b0;
            o_test_ray   <= '0;
            o_test_bbox  <= '0;
            o_leaf_valid <= 1'b0;
            o_leaf_prim  <= '0;
            leaf         <= 1'b0;
            left         <= '0;
            right        <= '0;
            prim         <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    o_test_ray <= i_ray;
                    sp         <= 1;
                    o_overflow <= 1'b0;
                    o_busy     <= 1'b1;
                    state      <= POP;
                end
                POP: if (sp == '0) begin
                    o_done <= 1'b1;
                    state  <= DONE;
                end else begin
                    sp          <= sp - 1'b1;
                    o_node_addr <= stack[top_idx];
                    o_node_rd   <= 1'b1;
                    state       <= FETCH;
                end
                FETCH: begin
                    o_node_rd <= 1'b0;
                    state     <= WAITN;
                end
                WAITN: if (i_node_rvalid) begin
                    o_test_bbox  <= i_node_bbox;
                    leaf         <= i_node_leaf;
                    left         <= i_node_left;
                    right        <= i_node_right;
                    prim         <= i_node_prim;
                    o_test_start <= 1'b1;
                    state        <= TEST;
                end
                TEST: begin
                    o_test_start <= 1'b0;
                    state        <= WAITT;
                end
                WAITT: if (i_test_done) begin
                    o_leaf_valid <= i_test_hit && leaf;
                    o_leaf_prim  <= i_test_hit && leaf ? prim : o_leaf_prim;
                    state        <= !i_test_hit ? POP : leaf ? EMIT : PUSHR;
                end
                EMIT: if (i_leaf_ready) begin
                    o_leaf_valid <= 1'b0;
                    state        <= POP;
                end
                PUSHR, PUSHL: begin
                    if (sp == FULL) o_overflow <= 1'b1;
                    else sp <= sp + 1'b1;
                    state <= state == PUSHR ? PUSHL : POP;
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BVH_TRAV_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_nodes_tested <= '0;
            o_leaves_hit   <= '0;
        end else if (state == IDLE && i_start) begin
            o_nodes_tested <= '0;
            o_leaves_hit   <= '0;
        end else begin
            if (state == WAITT && i_test_done && o_nodes_tested != 16'hFFFF) o_nodes_tested <= o_nodes_tested + 1'b1;
            if (state == EMIT && i_leaf_ready && o_leaves_hit != 16'hFFFF) o_leaves_hit <= o_leaves_hit + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bvh_traverse_ctrl.sv
// tb_bvh_traverse_ctrl: directed bench with node-memory, box-tester and leaf-sink responders.
module tb_bvh_traverse_ctrl;
    logic                         clk = 1'b0;
    logic                         i_rst = 1'b1;
    logic                         i_start = 1'b0;
    logic signed [0:1][0:2][31:0] ray;
    logic [15:0]                  i_root = '0;
    logic                         o_busy, o_done, o_overflow, o_node_rd;
    logic [15:0]                  o_node_addr;
    logic                         node_rvalid = 1'b0;
    logic signed [0:1][0:2][31:0] node_bbox = '0;
    logic                         node_leaf = 1'b0;
    logic [15:0]                  node_left = '0, node_right = '0, node_prim = '0;
    logic                         o_test_start;
    logic signed [0:1][0:2][31:0] o_test_ray, o_test_bbox;
    logic                         test_done = 1'b0, test_hit = 1'b0;
    logic                         o_leaf_valid;
    logic [15:0]                  o_leaf_prim;
    logic                         leaf_ready = 1'b0;

    bvh_traverse_ctrl #(.FRA_BITS(16), .NODE_AW(16), .PRIM_W(16), .STACK_DEPTH(2)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_ray(ray), .i_root(i_root),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow),
        .o_node_rd(o_node_rd), .o_node_addr(o_node_addr),
        .i_node_rvalid(node_rvalid), .i_node_bbox(node_bbox), .i_node_leaf(node_leaf),
        .i_node_left(node_left), .i_node_right(node_right), .i_node_prim(node_prim),
        .o_test_start(o_test_start), .o_test_ray(o_test_ray), .o_test_bbox(o_test_bbox),
        .i_test_done(test_done), .i_test_hit(test_hit),
        .o_leaf_valid(o_leaf_valid), .o_leaf_prim(o_leaf_prim), .i_leaf_ready(leaf_ready)
    );

    always #5 clk = ~clk;

    logic leaf_t [32];
    logic hit_t [32];
    int   left_t [32], right_t [32], prim_t [32];
    int   rd_log [$], leaf_log [$];
    int   checks = 0, failures = 0;
    int   tests = 0, done_cnt = 0, bad = 0, stalled = 0, stall = 0;
    int   pend = 0, cur = 0;
    bit   rd_pend = 0, t_pend = 0, stall_act = 0;
    logic [15:0] held = '0;

    function automatic logic signed [0:1][0:2][31:0] mkbox(input int a);
        logic signed [0:1][0:2][31:0] b;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                b[i][j] = 32'(i == 0 ? -(a * 16 + j) : a * 16 + j + 100);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Node memory (1-cycle latency), box tester (1-cycle latency) and leaf sink with optional stall.
    always @(negedge clk) begin
        node_rvalid = 1'b0;
        test_done   = 1'b0;
        test_hit    = 1'b0;
        if (rd_pend) begin
            node_rvalid = 1'b1;
            node_bbox   = mkbox(pend);
            node_leaf   = leaf_t[pend];
            node_left   = 16'(left_t[pend]);
            node_right  = 16'(right_t[pend]);
            node_prim   = 16'(prim_t[pend]);
            cur         = pend;
            rd_pend     = 1'b0;
        end
        if (o_node_rd) begin
            rd_log.push_back(int'(o_node_addr));
            pend    = int'(o_node_addr[4:0]);
            rd_pend = 1'b1;
        end
        if (t_pend) begin
            test_done = 1'b1;
            test_hit  = hit_t[cur];
            t_pend    = 1'b0;
        end
        if (o_test_start) begin
            tests++;
            t_pend = 1'b1;
        end
        if (o_done) done_cnt++;
        if (o_node_rd && o_leaf_valid) bad++;
        if (o_leaf_valid) begin
            if (stall_act && o_leaf_prim != held) bad++;
            held = o_leaf_prim;
            if (stall > 0) begin
                leaf_ready = 1'b0;
                stall--;
                stalled++;
                stall_act = 1'b1;
            end else begin
                leaf_ready = 1'b1;
                leaf_log.push_back(int'(o_leaf_prim));
                stall_act = 1'b0;
            end
        end else leaf_ready = 1'b0;
    end

    task automatic go(input logic [15:0] root, input int extra);
        rd_log.delete();
        leaf_log.delete();
        tests = 0; done_cnt = 0; bad = 0; stalled = 0;
        @(negedge clk);
        i_root  = root;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 1; i < 400 && done_cnt == 0; i++) begin
            if (i == extra) begin
                i_root  = 16'd5;
                i_start = 1'b1;
            end
            @(negedge clk);
            i_start = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after", o_busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                ray[i][j] = 32'(i * 1000 - j * 77 + 12345);
        for (int i = 0; i < 32; i++) begin
            leaf_t[i] = 1'b1; hit_t[i] = 1'b0;
            left_t[i] = 0; right_t[i] = 0; prim_t[i] = 0;
        end
        leaf_t[5] = 1'b1; prim_t[5] = 7; hit_t[5] = 1'b1;
        leaf_t[0] = 1'b0; left_t[0] = 1; right_t[0] = 2;
        leaf_t[1] = 1'b1; prim_t[1] = 10; hit_t[1] = 1'b1;
        leaf_t[2] = 1'b1; prim_t[2] = 20; hit_t[2] = 1'b1;
        leaf_t[8]  = 1'b0; left_t[8]  = 9;  right_t[8]  = 12; hit_t[8]  = 1'b1;
        leaf_t[9]  = 1'b0; left_t[9]  = 10; right_t[9]  = 13; hit_t[9]  = 1'b1;
        leaf_t[10] = 1'b0; left_t[10] = 11; right_t[10] = 14; hit_t[10] = 1'b1;
        leaf_t[11] = 1'b0; left_t[11] = 15; right_t[11] = 16; hit_t[11] = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_rd", o_node_rd, 0);
        chk("rst_tstart", o_test_start, 0);
        chk("rst_lvalid", o_leaf_valid, 0);
        chk("rst_addr", o_node_addr, 0);
        chk("rst_ray", o_test_ray, 0);
        i_rst = 1'b0;

        go(16'd5, 0);
        chk("t1_reads", rd_log.size(), 1);
        chk("t1_addr", rd_log[0], 5);
        chk("t1_tests", tests, 1);
        chk("t1_leaves", leaf_log.size(), 1);
        chk("t1_prim", leaf_log[0], 7);
        chk("t1_ovf", o_overflow, 0);
        chk("t1_ray", o_test_ray, ray);
        chk("t1_bbox", o_test_bbox, mkbox(5));

        hit_t[0] = 1'b0;
        go(16'd0, 0);
        chk("t2_reads", rd_log.size(), 1);
        chk("t2_addr", rd_log[0], 0);
        chk("t2_leaves", leaf_log.size(), 0);
        chk("t2_tests", tests, 1);

        hit_t[0] = 1'b1;
        go(16'd0, 0);
        chk("t3_reads", rd_log.size(), 3);
        chk("t3_rd0", rd_log[0], 0);
        chk("t3_rd1", rd_log[1], 1);
        chk("t3_rd2", rd_log[2], 2);
        chk("t3_leaves", leaf_log.size(), 2);
        chk("t3_leaf0", leaf_log[0], 10);
        chk("t3_leaf1", leaf_log[1], 20);
        chk("t3_ovf", o_overflow, 0);

        stall = 4;
        go(16'd0, 0);
        chk("t4_stalled", stalled, 4);
        chk("t4_hold_bad", bad, 0);
        chk("t4_rd2", rd_log[2], 2);
        chk("t4_leaf0", leaf_log[0], 10);
        chk("t4_leaf1", leaf_log[1], 20);

        go(16'd8, 0);
        chk("t5_ovf", o_overflow, 1);
        chk("t5_reads", rd_log.size(), 4);
        chk("t5_rd1", rd_log[1], 9);
        chk("t5_rd2", rd_log[2], 13);
        chk("t5_rd3", rd_log[3], 12);
        chk("t5_tests", tests, 4);

        go(16'd0, 3);
        chk("t6_ovf_clr", o_overflow, 0);
        chk("t6_reads", rd_log.size(), 3);
        chk("t6_rd0", rd_log[0], 0);
        chk("t6_rd2", rd_log[2], 2);

        @(negedge clk);
        i_root  = 16'd0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 20 && !o_node_rd; i++) @(negedge clk);
        @(negedge clk);
        chk("t7_busy_pre", o_busy, 1);
        #1 i_rst = 1'b1;
        #1;
        chk("t7_busy", o_busy, 0);
        chk("t7_addr", o_node_addr, 0);
        chk("t7_bbox", o_test_bbox, 0);
        chk("t7_ray", o_test_ray, 0);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        go(16'd5, 0);
        chk("t7_rd0", rd_log[0], 5);
        chk("t7_prim", leaf_log[0], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bvh_traverse_ctrl.md
Name: bvh_traverse_ctrl

Overview:
- Initiator side of the ray/box test interface. Walks a BVH for one fixed-point ray and fetches nodes from node memory.
- Issues each node's bbox plus the ray to a ray-box tester, pushes the children of internal nodes that hit, and streams out the primitive indices of leaves that hit.
- Sits between the ray dispatcher and the triangle-intersection stage.

Parameters:
- FRA_BITS, 16, fractional bits of ray/bbox fixed-point words (passed through, no arithmetic here).
- NODE_AW, 16, width of node index / node memory address.
- PRIM_W, 16, width of leaf primitive index.
- STACK_DEPTH, 16, entries in traversal stack (power of 2, >=2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle pulse; latches i_ray and i_root when idle.
- i_ray  in  signed 32 [0:1][0:2]  [0]=origin, [1]=direction.
- i_root  in  NODE_AW  root node index.
- o_busy  out  1  high from accepted start until done pulse.
- o_done  out  1  one-cycle pulse when traversal ends.
- o_overflow  out  1  sticky; a push was dropped because the stack was full. Cleared on start.
- o_node_rd  out  1  one-cycle node read request.
- o_node_addr  out  NODE_AW  node index being read.
- i_node_rvalid  in  1  node data valid (any latency >=1 cycle).
- i_node_bbox  in  signed 32 [0:1][0:2]  [0]=min, [1]=max.
- i_node_leaf  in  1  node is a leaf.
- i_node_left  in  NODE_AW  left child index.
- i_node_right  in  NODE_AW  right child index.
- i_node_prim  in  PRIM_W  leaf primitive index.
- o_test_start  out  1  one-cycle pulse launching a box test.
- o_test_ray  out  signed 32 [0:1][0:2]  latched ray; constant for the whole traversal.
- o_test_bbox  out  signed 32 [0:1][0:2]  latched bbox; stable from start until done.
- i_test_done  in  1  tester result valid (one cycle).
- i_test_hit  in  1  tester intersect result; sampled only with i_test_done.
- o_leaf_valid  out  1  leaf hit available.
- o_leaf_prim  out  PRIM_W  primitive index of the leaf hit.
- i_leaf_ready  in  1  downstream accepts the leaf.

Behaviour:
- Reset (async, any state): state=IDLE, stack pointer=0.
  - All outputs 0: o_busy, o_done, o_overflow, o_node_rd, o_test_start, o_leaf_valid, addresses/data.
- FSM states: IDLE, POP, FETCH, WAITN, TEST, WAITT, EMIT, PUSHR, PUSHL, DONE.
- IDLE, i_start=1: latch ray, write i_root to stack[0], sp=1, clear o_overflow, o_busy=1 next cycle, go POP.
- i_start in any non-IDLE state is ignored. No effect on the latched ray or the stack.
- POP:
  - sp==0: go DONE.
  - Otherwise sp-=1, index=stack[sp-1], go FETCH.
- FETCH: o_node_rd=1 for exactly one cycle with o_node_addr=index, go WAITN.
- WAITN: on i_node_rvalid latch bbox, leaf, left, right and prim, go TEST. rvalid in any other state is ignored.
- TEST: o_test_start=1 for one cycle, go WAITT. o_test_bbox/o_test_ray held unchanged until i_test_done.
- WAITT, on i_test_done:
  - hit=0: go POP.
  - hit=1 and leaf: go EMIT.
  - hit=1 and internal: go PUSHR.
- EMIT: o_leaf_valid=1, o_leaf_prim stable until the cycle with i_leaf_ready=1. Transfer completes that cycle; go POP.
- PUSHR: push right child, go PUSHL. PUSHL: push left child, go POP. Left is popped first.
- Push with sp==STACK_DEPTH: entry dropped, o_overflow<=1, traversal continues.
- DONE: o_done=1 one cycle, o_busy<=0, go IDLE.
- Minimum per node: miss = 5 cycles (POP, FETCH, WAITN>=1, TEST, WAITT>=1); internal hit adds 2 cycles.
- No arithmetic on ray/bbox; widths pass through unchanged.

Optional Feature:
- Macro BVH_TRAV_STATS_EN.
- Defined: adds outputs o_nodes_tested[15:0] and o_leaves_hit[15:0].
  - o_nodes_tested increments on each i_test_done; o_leaves_hit increments on each leaf transfer.
  - Both saturate at 16'hFFFF, clear on accepted start and on reset, and hold after done.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Leaf root idx 5, prim 7, tester hit -> one o_node_rd addr 5, one o_test_start, o_leaf_prim=7 accepted, then o_done pulse; o_overflow=0.
- Internal root idx 0 (left=1, right=2), tester misses root -> single read addr 0, no leaf output, o_done after 1 test.
- Root hit, children leaves 1 (prim 10) and 2 (prim 20) both hit -> read order 0,1,2; leaf outputs 10 then 20; done.
- Same tree, i_leaf_ready low 4 cycles on first leaf -> o_leaf_valid held, prim 10 stable, no read of node 2 until transfer.
- STACK_DEPTH=2, left-degenerate tree of 4 internal nodes all hit -> o_overflow=1, traversal still ends with o_done.
- i_rst asserted during WAITN, then i_start with new root -> outputs 0 immediately on reset; new traversal reads the new root first. Extra i_start while busy is ignored.
